// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipe: stage enables/flushes, load-use bubble,
// EXE forwarding selects, data-memory req/ack handshake with timeout, saturating stall counter.
module pipe_hazard_ctrl #(
   parameter logic [1:0] LOAD_WBSEL = 2'b01,
   parameter int         CNT_W      = 32,
   parameter int         DM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UseRs,
   input  logic             ID_UseRt,
   input  logic [4:0]       EXE_Rs,
   input  logic [4:0]       EXE_Rt,
   input  logic [4:0]       EXE_Rw,
   input  logic             EXE_RfWr,
   input  logic [1:0]       EXE_WbSel,
   input  logic             EXE_Redirect,
   input  logic [4:0]       MEM_Rw,
   input  logic             MEM_RfWr,
   input  logic [1:0]       MEM_WbSel,
   input  logic             MEM_DmAcc,
   input  logic [4:0]       WB_Rw,
   input  logic             WB_RfWr,
   input  logic             DmAck,
   input  logic [31:0]      DmRData,
   output logic             DmReq,
   output logic [31:0]      MEM_DmOut,
   output logic             PC_En,
   output logic             IFID_En,
   output logic             IDEXE_En,
   output logic             EXEMEM_En,
   output logic             MEMWB_En,
   output logic             IFID_Flush,
   output logic             IDEXE_Flush,
   output logic             EXEMEM_Flush,
   output logic             MEMWB_Flush,
   output logic [1:0]       FwdA,
   output logic [1:0]       FwdB,
   output logic             DmErr,
   output logic [CNT_W-1:0] StallCnt
);

   localparam int TO_W = (DM_TIMEOUT > 0) ? $clog2(DM_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} dm_state_t;

   dm_state_t        state, state_nxt;
   logic [TO_W-1:0]  wait_cnt, wait_cnt_nxt;
   logic [31:0]      dm_data, dm_data_nxt;
   logic             dm_err_nxt;
   logic             dm_busy;
   logic             load_use;
   logic             timed_out;
   logic [CNT_W-1:0] stall_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Register 0 is hardwired zero, so it is never a forwarding target.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      if (src == 5'd0)
         return 2'b00;
      if (MEM_RfWr && (MEM_Rw == src) && (MEM_WbSel != LOAD_WBSEL))
         return 2'b10;
      if (WB_RfWr && (WB_Rw == src))
         return 2'b01;
      return 2'b00;
   endfunction

   assign load_use = EXE_RfWr && (EXE_WbSel == LOAD_WBSEL) && (EXE_Rw != 5'd0) &&
                     ((ID_UseRs && (ID_Rs == EXE_Rw)) || (ID_UseRt && (ID_Rt == EXE_Rw)));

   assign timed_out = (DM_TIMEOUT != 0) && (wait_cnt == TO_W'(DM_TIMEOUT));

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      dm_data_nxt  = dm_data;
      dm_err_nxt   = DmErr;
      dm_busy      = 1'b0;
      DmReq        = 1'b0;
      MEM_DmOut    = dm_data;
      unique case (state)
         IDLE: begin
            DmReq = MEM_DmAcc;
            if (MEM_DmAcc && DmAck) begin
               MEM_DmOut = DmRData;
            end else if (MEM_DmAcc) begin
               state_nxt    = WAIT;
               wait_cnt_nxt = TO_W'(1);
            end
         end
         WAIT: begin
            DmReq        = 1'b1;
            dm_busy      = 1'b1;
            wait_cnt_nxt = wait_cnt + TO_W'(1);
            if (DmAck) begin
               dm_data_nxt = DmRData;
               state_nxt   = DONE;
            end else if (timed_out) begin
               dm_err_nxt  = 1'b1;
               dm_data_nxt = '0;
               state_nxt   = DONE;
            end
         end
         // DONE keeps the request low for one cycle so the same access is not re-issued.
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (rst)
         DmReq = 1'b0;
   end

   always_comb begin
      PC_En        = 1'b1;
      IFID_En      = 1'b1;
      IDEXE_En     = 1'b1;
      EXEMEM_En    = 1'b1;
      MEMWB_En     = 1'b1;
      IFID_Flush   = 1'b0;
      IDEXE_Flush  = 1'b0;
      EXEMEM_Flush = 1'b0;
      MEMWB_Flush  = 1'b0;
      if (rst) begin
         {PC_En, IFID_En, IDEXE_En, EXEMEM_En, MEMWB_En} = '0;
         {IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEMWB_Flush} = '1;
      end else if (dm_busy) begin
         {PC_En, IFID_En, IDEXE_En, EXEMEM_En, MEMWB_En} = '0;
      end else if (EXE_Redirect) begin
         IFID_Flush  = 1'b1;
         IDEXE_Flush = 1'b1;
      end else if (load_use) begin
         PC_En       = 1'b0;
         IFID_En     = 1'b0;
         IDEXE_Flush = 1'b1;
      end
   end

   assign FwdA     = rst ? 2'b00 : fwd_sel(EXE_Rs);
   assign FwdB     = rst ? 2'b00 : fwd_sel(EXE_Rt);
   assign StallCnt = stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dm_data   <= '0;
         DmErr     <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         dm_data  <= dm_data_nxt;
         DmErr    <= dm_err_nxt;
         if (!PC_En)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

   always_ff @(posedge clk) begin
      wait_cnt <= wait_cnt_nxt;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then a
// randomized run checked every cycle against a behavioural model of the controller.
module tb_pipe_hazard_ctrl;

   localparam logic [1:0] LOAD_WBSEL = 2'b01;
   localparam int         CNT_W      = 6;
   localparam int         DM_TO      = 4;
   localparam int         SAT        = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       ID_Rs, ID_Rt, EXE_Rs, EXE_Rt, EXE_Rw, MEM_Rw, WB_Rw;
   logic             ID_UseRs, ID_UseRt, EXE_RfWr, EXE_Redirect, MEM_RfWr, MEM_DmAcc;
   logic             WB_RfWr, DmAck;
   logic [1:0]       EXE_WbSel, MEM_WbSel;
   logic [31:0]      DmRData;
   logic             DmReq, DmErr;
   logic [31:0]      MEM_DmOut;
   logic             PC_En, IFID_En, IDEXE_En, EXEMEM_En, MEMWB_En;
   logic             IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEMWB_Flush;
   logic [1:0]       FwdA, FwdB;
   logic [CNT_W-1:0] StallCnt;
   logic [8:0]       ctl;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Behavioural model state
   bit          model_ok = 0;
   bit          m_wait, m_done, m_err;
   int          m_wn, m_stall;
   logic [31:0] m_data;

   pipe_hazard_ctrl #(.LOAD_WBSEL(LOAD_WBSEL), .CNT_W(CNT_W), .DM_TIMEOUT(DM_TO)) dut (
      .clk(clk), .rst(rst),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
      .EXE_Rs(EXE_Rs), .EXE_Rt(EXE_Rt), .EXE_Rw(EXE_Rw), .EXE_RfWr(EXE_RfWr),
      .EXE_WbSel(EXE_WbSel), .EXE_Redirect(EXE_Redirect),
      .MEM_Rw(MEM_Rw), .MEM_RfWr(MEM_RfWr), .MEM_WbSel(MEM_WbSel), .MEM_DmAcc(MEM_DmAcc),
      .WB_Rw(WB_Rw), .WB_RfWr(WB_RfWr), .DmAck(DmAck), .DmRData(DmRData),
      .DmReq(DmReq), .MEM_DmOut(MEM_DmOut),
      .PC_En(PC_En), .IFID_En(IFID_En), .IDEXE_En(IDEXE_En), .EXEMEM_En(EXEMEM_En),
      .MEMWB_En(MEMWB_En), .IFID_Flush(IFID_Flush), .IDEXE_Flush(IDEXE_Flush),
      .EXEMEM_Flush(EXEMEM_Flush), .MEMWB_Flush(MEMWB_Flush),
      .FwdA(FwdA), .FwdB(FwdB), .DmErr(DmErr), .StallCnt(StallCnt)
   );

   always #5 clk = ~clk;

   assign ctl = {PC_En, IFID_En, IDEXE_En, EXEMEM_En, MEMWB_En,
                 IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEMWB_Flush};

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit exp_load_use();
      logic [4:0] srcs[2];
      bit         used[2];
      srcs = '{ID_Rs, ID_Rt};
      used = '{ID_UseRs, ID_UseRt};
      if (!EXE_RfWr || EXE_WbSel != LOAD_WBSEL || EXE_Rw == 5'd0)
         return 0;
      foreach (srcs[i])
         if (used[i] && srcs[i] == EXE_Rw)
            return 1;
      return 0;
   endfunction

   // {PC,IFID,IDEXE,EXEMEM,MEMWB enables, IFID,IDEXE,EXEMEM,MEMWB flushes}
   function automatic logic [8:0] exp_ctl();
      if (rst)            return 9'b00000_1111;
      if (m_wait)         return 9'b00000_0000;
      if (EXE_Redirect)   return 9'b11111_1100;
      if (exp_load_use()) return 9'b00111_0100;
      return 9'b11111_0000;
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] src);
      if (rst || src == 5'd0)                                          return 2'b00;
      if (MEM_RfWr && MEM_Rw == src && MEM_WbSel != LOAD_WBSEL)        return 2'b10;
      if (WB_RfWr && WB_Rw == src)                                     return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic exp_req();
      if (rst)    return 1'b0;
      if (m_wait) return 1'b1;
      if (m_done) return 1'b0;
      return MEM_DmAcc;
   endfunction

   function automatic logic [31:0] exp_dout();
      if (!m_wait && !m_done && MEM_DmAcc && DmAck)
         return DmRData;
      return m_data;
   endfunction

   // Model advance on each rising edge
   initial begin
      logic [8:0] e;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_wait = 0; m_done = 0; m_err = 0; m_wn = 0; m_data = '0; m_stall = 0;
            model_ok = 1;
         end else if (model_ok) begin
            e = exp_ctl();
            if (!e[8] && m_stall < SAT)
               m_stall++;
            if (m_wait) begin
               m_wn++;
               if (DmAck) begin
                  m_data = DmRData; m_wait = 0; m_done = 1;
               end else if (DM_TO != 0 && m_wn == DM_TO) begin
                  m_err = 1; m_data = '0; m_wait = 0; m_done = 1;
               end
            end else if (m_done) begin
               m_done = 0;
            end else if (MEM_DmAcc && !DmAck) begin
               m_wait = 1; m_wn = 0;
            end
         end
      end
   end

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            check("ctl", 64'(ctl), 64'(exp_ctl()));
            check("dmreq", 64'(DmReq), 64'(exp_req()));
            check("fwda", 64'(FwdA), 64'(exp_fwd(EXE_Rs)));
            check("fwdb", 64'(FwdB), 64'(exp_fwd(EXE_Rt)));
            check("stallcnt", 64'(StallCnt), 64'(m_stall));
            check("dmerr", 64'(DmErr), 64'(m_err));
            if (!rst)
               check("dmout", 64'(MEM_DmOut), 64'(exp_dout()));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run still active at %0t, limit 500000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      @(negedge clk);
   endtask

   task automatic clr();
      ID_Rs = '0; ID_Rt = '0; ID_UseRs = 0; ID_UseRt = 0;
      EXE_Rs = '0; EXE_Rt = '0; EXE_Rw = '0; EXE_RfWr = 0; EXE_WbSel = '0; EXE_Redirect = 0;
      MEM_Rw = '0; MEM_RfWr = 0; MEM_WbSel = '0; MEM_DmAcc = 0;
      WB_Rw = '0; WB_RfWr = 0; DmAck = 0; DmRData = '0;
   endtask

   task automatic set_load_use();
      EXE_Rw = 5'd5; EXE_RfWr = 1; EXE_WbSel = LOAD_WBSEL;
      ID_Rs = 5'd5; ID_UseRs = 1; ID_Rt = 5'd7; ID_UseRt = 1;
   endtask

   initial begin
      rst = 1;
      clr();
      // Reset behaviour
      tick(); tick(); probe();
      check("t1_ctl_rst", 64'(ctl), 64'(9'b00000_1111));
      check("t1_dmreq_rst", 64'(DmReq), 64'(0));
      tick(); rst = 0; probe();
      check("t1_ctl_run", 64'(ctl), 64'(9'b11111_0000));
      check("t1_stall0", 64'(StallCnt), 64'(0));

      // Load-use bubble
      tick(); set_load_use(); probe();
      check("t2_ctl", 64'(ctl), 64'(9'b00111_0100));
      tick(); clr(); probe();
      check("t2_pc_en", 64'(PC_En), 64'(1));
      check("t2_stall", 64'(StallCnt), 64'(1));

      // Forwarding
      tick(); MEM_RfWr = 1; MEM_Rw = 5'd3; WB_RfWr = 1; WB_Rw = 5'd3; EXE_Rs = 5'd3; EXE_Rt = 5'd0;
      probe();
      check("t3_fwda_mem", 64'(FwdA), 64'(2'b10));
      check("t3_fwdb_r0", 64'(FwdB), 64'(2'b00));
      tick(); MEM_Rw = 5'd0; probe();
      check("t3_fwda_wb", 64'(FwdA), 64'(2'b01));
      check("t3_fwdb_r0_mem0", 64'(FwdB), 64'(2'b00));
      tick(); MEM_Rw = 5'd3; MEM_WbSel = LOAD_WBSEL; probe();
      check("t3_fwda_memload", 64'(FwdA), 64'(2'b01));

      // DM access with ack three cycles after the request
      tick(); clr(); MEM_DmAcc = 1; probe();
      check("t4_c0_req", 64'(DmReq), 64'(1));
      check("t4_c0_pc", 64'(PC_En), 64'(1));
      tick(); probe();
      check("t4_c1_ctl", 64'(ctl), 64'(0));
      check("t4_c1_req", 64'(DmReq), 64'(1));
      tick(); probe();
      check("t4_c2_ctl", 64'(ctl), 64'(0));
      tick(); DmAck = 1; DmRData = 32'hDEADBEEF; probe();
      check("t4_c3_ctl", 64'(ctl), 64'(0));
      tick(); DmAck = 0; DmRData = '0; probe();
      check("t4_done_req", 64'(DmReq), 64'(0));
      check("t4_done_data", 64'(MEM_DmOut), 64'(32'hDEADBEEF));
      check("t4_done_pc", 64'(PC_En), 64'(1));
      check("t4_stall", 64'(StallCnt), 64'(4));
      tick(); clr(); probe();
      check("t4_hold_data", 64'(MEM_DmOut), 64'(32'hDEADBEEF));

      // Redirect vs load-use, and redirect held through a DM freeze
      tick(); set_load_use(); EXE_Redirect = 1; probe();
      check("t5_redir_ctl", 64'(ctl), 64'(9'b11111_1100));
      tick(); clr(); MEM_DmAcc = 1; probe();
      tick(); EXE_Redirect = 1; probe();
      check("t5_wait_ctl", 64'(ctl), 64'(0));
      tick(); DmAck = 1; probe();
      check("t5_ack_ctl", 64'(ctl), 64'(0));
      tick(); DmAck = 0; probe();
      check("t5_done_ctl", 64'(ctl), 64'(9'b11111_1100));
      check("t5_stall", 64'(StallCnt), 64'(6));

      // Timeout, then reset in the middle of WAIT
      tick(); clr(); MEM_DmAcc = 1; probe();
      for (int k = 1; k <= DM_TO; k++) begin
         tick(); probe();
         check("t6_wait_err", 64'(DmErr), 64'(0));
         check("t6_wait_req", 64'(DmReq), 64'(1));
      end
      tick(); probe();
      check("t6_err", 64'(DmErr), 64'(1));
      check("t6_done_req", 64'(DmReq), 64'(0));
      check("t6_done_data", 64'(MEM_DmOut), 64'(0));
      tick(); probe();
      check("t6_idle_req", 64'(DmReq), 64'(1));
      tick(); probe();
      check("t6_wait2_pc", 64'(PC_En), 64'(0));
      tick(); rst = 1; probe();
      check("t6_rst_req", 64'(DmReq), 64'(0));
      tick(); rst = 0; probe();
      check("t6_post_req", 64'(DmReq), 64'(1));
      check("t6_post_pc", 64'(PC_En), 64'(1));
      check("t6_post_err", 64'(DmErr), 64'(0));
      check("t6_post_stall", 64'(StallCnt), 64'(0));

      // Randomized run
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst          = ($urandom_range(0, 399) == 0);
         ID_Rs        = 5'($urandom_range(0, 3));
         ID_Rt        = 5'($urandom_range(0, 3));
         ID_UseRs     = 1'($urandom_range(0, 1));
         ID_UseRt     = 1'($urandom_range(0, 1));
         EXE_Rs       = 5'($urandom_range(0, 3));
         EXE_Rt       = 5'($urandom_range(0, 3));
         EXE_Rw       = 5'($urandom_range(0, 3));
         EXE_RfWr     = 1'($urandom_range(0, 1));
         EXE_WbSel    = 2'($urandom_range(0, 3));
         EXE_Redirect = ($urandom_range(0, 9) == 0);
         MEM_Rw       = 5'($urandom_range(0, 3));
         MEM_RfWr     = 1'($urandom_range(0, 1));
         MEM_WbSel    = 2'($urandom_range(0, 3));
         MEM_DmAcc    = ($urandom_range(0, 9) < 3);
         WB_Rw        = 5'($urandom_range(0, 3));
         WB_RfWr      = 1'($urandom_range(0, 1));
         DmAck        = ($urandom_range(0, 9) < 4);
         DmRData      = $urandom;
      end
      tick(); rst = 0; clr(); probe();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
